alu_rr_sched: RTL and testbench



---
 rtl/alu_rr_sched_pkg.sv | 31 +++
 rtl/alu_rr_arb.sv | 29 ++
 rtl/alu_rr_sched.sv | 211 +++++++++++++++++++++
 tb/tb_alu_rr_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rr_sched_pkg.sv
// alu_rr_sched_pkg: ALU opcodes, scheduler FSM states and width defaults shared by the
// round-robin ALU scheduler. Build option ALU_RR_SCHED_ILLEGAL_FILTER_EN uses is_invalid_op().
package alu_rr_sched_pkg;

   localparam int unsigned DefDataW = 4;
   localparam int unsigned DefCtlW  = 4;

   // Opcodes understood by the shared ALU; the two invalid codes never raise valid_out.
   typedef enum logic [DefCtlW-1:0] {
      OpAdd      = 4'h0,
      OpSub      = 4'h1,
      OpAnd      = 4'h2,
      OpOr       = 4'h3,
      OpXor      = 4'h4,
      OpNotA     = 4'h5,
      OpInvalid1 = 4'h6,
      OpInvalid2 = 4'h7
   } alu_op_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } sched_state_e;

   function automatic logic is_invalid_op(input logic [DefCtlW-1:0] ctl);
      return (ctl == OpInvalid1) || (ctl == OpInvalid2);
   endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// alu_rr_arb: combinational round-robin grant. Search starts one past ptr_i and wraps.
module alu_rr_arb #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req_valid_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [IdxW-1:0]   gnt_idx_o,
   output logic              any_valid_o
);

   // First valid requester at or after ptr_i+1 (mod NumReq)
   always_comb begin
      int unsigned cand;
      cand        = 0;
      gnt_idx_o   = '0;
      any_valid_o = 1'b0;
      for (int unsigned k = 1; k <= NumReq; k++) begin
         cand = (32'(ptr_i) + k) % NumReq;
         if (!any_valid_o && req_valid_i[cand[IdxW-1:0]]) begin
            any_valid_o = 1'b1;
            gnt_idx_o   = cand[IdxW-1:0];
         end
      end
      gnt_o = any_valid_o ? (NumReq'(1) << gnt_idx_o) : '0;
   end

endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: shares one ALU among NUM_REQ requesters, one op in flight at a time.
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE. WAIT times out after TIMEOUT cycles with err set.
// Build option ALU_RR_SCHED_ILLEGAL_FILTER_EN: invalid opcodes are answered from IDLE with
// err set and never reach the ALU.
module alu_rr_sched
   import alu_rr_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned CTL_W   = DefCtlW,
   parameter int unsigned TIMEOUT = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   input  logic [NUM_REQ-1:0]          req_cin,
   input  logic [NUM_REQ*CTL_W-1:0]    req_ctl,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic [DATA_W-1:0]           rsp_alu,
   output logic                        rsp_carry,
   output logic                        rsp_zero,
   output logic                        rsp_err,
   output logic                        alu_valid_in,
   output logic [DATA_W-1:0]           alu_a,
   output logic [DATA_W-1:0]           alu_b,
   output logic                        alu_cin,
   output logic [CTL_W-1:0]            alu_ctl,
   input  logic                        alu_valid_out,
   input  logic [DATA_W-1:0]           alu_result,
   input  logic                        alu_carry,
   input  logic                        alu_zero
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   sched_state_e      state_d, state_q;
   logic [IdxW-1:0]   ptr_d, ptr_q;
   logic [IdxW-1:0]   id_d, id_q;
   logic [DATA_W-1:0] a_d, a_q, b_d, b_q;
   logic              cin_d, cin_q;
   logic [CTL_W-1:0]  ctl_d, ctl_q;
   logic [CntW-1:0]   cnt_d, cnt_q;
   logic [DATA_W-1:0] res_d, res_q;
   logic              carry_d, carry_q, zero_d, zero_q, err_d, err_q;
   logic              rsp_valid_d, rsp_valid_q;
   logic              alu_vin_d, alu_vin_q;

   logic [NUM_REQ-1:0] gnt;
   logic [IdxW-1:0]    gnt_idx;
   logic               any_valid;
   logic [DATA_W-1:0]  sel_a, sel_b;
   logic               sel_cin;
   logic [CTL_W-1:0]   sel_ctl;

   alu_rr_arb #(
      .NumReq (NUM_REQ),
      .IdxW   (IdxW)
   ) u_arb (
      .req_valid_i (req_valid),
      .ptr_i       (ptr_q),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .any_valid_o (any_valid)
   );

   // Operands of the currently granted requester
   always_comb begin
      sel_a   = req_a[32'(gnt_idx) * DATA_W +: DATA_W];
      sel_b   = req_b[32'(gnt_idx) * DATA_W +: DATA_W];
      sel_cin = req_cin[gnt_idx];
      sel_ctl = req_ctl[32'(gnt_idx) * CTL_W +: CTL_W];
   end

   // Next-state, accept strobe and registered-output next values
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      cin_d       = cin_q;
      ctl_d       = ctl_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      alu_vin_d   = 1'b0;
      req_ready   = '0;
      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               req_ready = gnt;
               ptr_d     = gnt_idx;
               id_d      = gnt_idx;
`ifdef ALU_RR_SCHED_ILLEGAL_FILTER_EN
               if (is_invalid_op(DefCtlW'(sel_ctl))) begin
                  // Answer immediately; ALU-facing regs keep their last values
                  res_d       = '0;
                  carry_d     = 1'b0;
                  zero_d      = 1'b0;
                  err_d       = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = StResp;
               end else begin
                  a_d       = sel_a;
                  b_d       = sel_b;
                  cin_d     = sel_cin;
                  ctl_d     = sel_ctl;
                  alu_vin_d = 1'b1;
                  state_d   = StIssue;
               end
`else
               a_d       = sel_a;
               b_d       = sel_b;
               cin_d     = sel_cin;
               ctl_d     = sel_ctl;
               alu_vin_d = 1'b1;
               state_d   = StIssue;
`endif
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (alu_valid_out) begin
               res_d       = alu_result;
               carry_d     = alu_carry;
               zero_d      = alu_zero;
               err_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CntW'(TIMEOUT)) begin
                  res_d       = '0;
                  carry_d     = 1'b0;
                  zero_d      = 1'b0;
                  err_d       = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = StResp;
               end
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         ptr_q       <= IdxW'(NUM_REQ - 1);
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         ctl_q       <= '0;
         cnt_q       <= '0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         alu_vin_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cin_q       <= cin_d;
         ctl_q       <= ctl_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         alu_vin_q   <= alu_vin_d;
      end
   end

   assign alu_valid_in = alu_vin_q;
   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_cin      = cin_q;
   assign alu_ctl      = ctl_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = id_q;
   assign rsp_alu      = res_q;
   assign rsp_carry    = carry_q;
   assign rsp_zero     = zero_q;
   assign rsp_err      = err_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: randomized and directed transactions against a transaction-level model
// of the scheduler (round-robin order, latency, ALU arithmetic, timeout/err).
module tb_alu_rr_sched;
   import alu_rr_sched_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned TO = 2;
   localparam int unsigned IW = $clog2(N);

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid, req_ready, req_cin;
   logic [N*DW-1:0] req_a, req_b;
   logic [N*CW-1:0] req_ctl;
   logic            rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_err;
   logic [IW-1:0]   rsp_id;
   logic [DW-1:0]   rsp_alu;
   logic            alu_valid_in, alu_cin, alu_valid_out, alu_carry, alu_zero;
   logic [DW-1:0]   alu_a, alu_b, alu_result;
   logic [CW-1:0]   alu_ctl;

   logic [DW-1:0] op_a[N];
   logic [DW-1:0] op_b[N];
   logic          op_cin[N];
   logic [CW-1:0] op_ctl[N];

   int n_cmp = 0;
   int n_bad = 0;
   int mptr;

   always #5 clk = ~clk;

   alu_rr_sched #(
      .NUM_REQ (N),
      .DATA_W  (DW),
      .CTL_W   (CW),
      .TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_cin       (req_cin),
      .req_ctl       (req_ctl),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_alu       (rsp_alu),
      .rsp_carry     (rsp_carry),
      .rsp_zero      (rsp_zero),
      .rsp_err       (rsp_err),
      .alu_valid_in  (alu_valid_in),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_cin       (alu_cin),
      .alu_ctl       (alu_ctl),
      .alu_valid_out (alu_valid_out),
      .alu_result    (alu_result),
      .alu_carry     (alu_carry),
      .alu_zero      (alu_zero)
   );

   // Reference arithmetic: returns {zero, carry, result}
   function automatic logic [DW+1:0] ref_alu(input int a, input int b, input int cin,
                                             input logic [CW-1:0] ctl);
      int s;
      int r;
      int c;
      s = 0;
      c = 0;
      case (ctl)
         OpAdd:   begin s = a + b + cin; c = (s >= 16) ? 1 : 0; end
         OpSub:   begin s = a - b - cin; c = (s < 0) ? 1 : 0; end
         OpAnd:   s = a & b;
         OpOr:    s = a | b;
         OpXor:   s = a ^ b;
         OpNotA:  s = 15 - a;
         default: s = 0;
      endcase
      r = (s + 32) % 16;
      return {(r == 0) ? 1'b1 : 1'b0, c[0], DW'(r)};
   endfunction

   function automatic logic op_ok(input logic [CW-1:0] ctl);
      return ctl <= 4'h5;
   endfunction

   // Behavioural ALU with one-cycle latency; invalid opcodes never answer
   always @(posedge clk) begin
      if (!reset) begin
         alu_valid_out <= 1'b0;
         alu_result    <= '0;
         alu_carry     <= 1'b0;
         alu_zero      <= 1'b0;
      end else if (alu_valid_in && op_ok(alu_ctl)) begin
         alu_valid_out                     <= 1'b1;
         {alu_zero, alu_carry, alu_result} <= ref_alu(int'(alu_a), int'(alu_b), int'(alu_cin),
                                                      alu_ctl);
      end else begin
         alu_valid_out <= 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_ops();
      for (int i = 0; i < int'(N); i++) begin
         req_a[i*DW +: DW]   = op_a[i];
         req_b[i*DW +: DW]   = op_b[i];
         req_cin[i]          = op_cin[i];
         req_ctl[i*CW +: CW] = op_ctl[i];
      end
   endtask

   task automatic rand_ops();
      for (int i = 0; i < int'(N); i++) begin
         op_a[i]   = DW'($urandom_range(0, 15));
         op_b[i]   = DW'($urandom_range(0, 15));
         op_cin[i] = 1'($urandom_range(0, 1));
         op_ctl[i] = CW'($urandom_range(0, 7));
      end
   endtask

   // One full transaction starting at a negedge with the DUT idle; ends at the negedge on
   // which the DUT is idle again.
   task automatic run_txn(input logic [N-1:0] vmask, input int stall);
      int g;
      int lat;
      logic bad;
      logic filt;
      logic [DW+1:0] exp;
      logic [DW-1:0] ea, eb;
      logic [CW-1:0] ectl;
      check_eq("idle_rsp_valid", rsp_valid, 0);
      drive_ops();
      req_valid = vmask;
      rsp_ready = 1'b0;
      #1;
      g = -1;
      for (int k = 1; k <= int'(N); k++) begin
         if (g < 0 && vmask[(mptr + k) % N]) g = (mptr + k) % N;
      end
      check_eq("req_ready", req_ready, 32'(1) << g);
      mptr = g;
      ea   = op_a[g];
      eb   = op_b[g];
      ectl = op_ctl[g];
      bad  = (ectl == OpInvalid1) || (ectl == OpInvalid2);
`ifdef ALU_RR_SCHED_ILLEGAL_FILTER_EN
      filt = bad;
`else
      filt = 1'b0;
`endif
      lat = filt ? 1 : (bad ? 2 + int'(TO) : 3);
      exp = bad ? '0 : ref_alu(int'(ea), int'(eb), int'(op_cin[g]), ectl);
      @(negedge clk);
      req_valid = '0;
      for (int c = 1; c < lat; c++) begin
         if (c == 1) begin
            check_eq("alu_valid_in", alu_valid_in, !filt);
            if (!filt) begin
               check_eq("alu_a", alu_a, ea);
               check_eq("alu_b", alu_b, eb);
               check_eq("alu_ctl", alu_ctl, ectl);
            end
         end else begin
            check_eq("alu_valid_in_lo", alu_valid_in, 0);
         end
         check_eq("rsp_valid_early", rsp_valid, 0);
         @(negedge clk);
      end
      for (int s = 0; s <= stall; s++) begin
         check_eq("rsp_valid", rsp_valid, 1);
         check_eq("rsp_id", rsp_id, g);
         check_eq("rsp_alu", rsp_alu, exp[DW-1:0]);
         check_eq("rsp_carry", rsp_carry, exp[DW]);
         check_eq("rsp_zero", rsp_zero, exp[DW+1]);
         check_eq("rsp_err", rsp_err, bad);
         if (s < stall) begin
            rand_ops();
            drive_ops();
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            #1;
            check_eq("resp_no_accept", req_ready, 0);
            @(negedge clk);
         end
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         op_a[i] = '0; op_b[i] = '0; op_cin[i] = 1'b0; op_ctl[i] = '0;
      end
      drive_ops();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      mptr  = N - 1;
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_alu_valid_in", alu_valid_in, 0);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_alu_a", alu_a, 0);
      check_eq("rst_rsp_err", rsp_err, 0);

      // ADD 3+4 from requester 0
      op_a[0] = 4'd3; op_b[0] = 4'd4; op_cin[0] = 1'b0; op_ctl[0] = OpAdd;
      run_txn(4'b0001, 0);
      // SUB 5-5 from requester 2 gives zero
      op_a[2] = 4'd5; op_b[2] = 4'd5; op_cin[2] = 1'b0; op_ctl[2] = OpSub;
      run_txn(4'b0100, 0);
      // All requesting back to back: rotation at 4-cycle spacing
      op_ctl[0] = OpXor; op_ctl[1] = OpAnd; op_ctl[3] = OpOr;
      repeat (5) run_txn(4'b1111, 0);
      // Invalid opcodes from requester 1
      op_ctl[1] = OpInvalid1;
      run_txn(4'b0010, 0);
      op_ctl[1] = OpInvalid2;
      run_txn(4'b0010, 1);
      // Response back-pressure with two requesters pending
      op_ctl[0] = OpAdd; op_ctl[1] = OpSub;
      run_txn(4'b0011, 5);
      run_txn(4'b0011, 0);

      for (int t = 0; t < 80; t++) begin
         rand_ops();
         run_txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 2)));
      end

      // Reset while waiting on the ALU
      op_a[3] = 4'd9; op_b[3] = 4'd2; op_ctl[3] = OpAdd;
      drive_ops();
      req_valid = 4'b1000;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("midrst_rsp_valid", rsp_valid, 0);
      check_eq("midrst_alu_valid_in", alu_valid_in, 0);
      check_eq("midrst_alu_a", alu_a, 0);
      reset = 1'b1;
      mptr  = N - 1;
      req_valid = 4'b1010;
      #1;
      check_eq("midrst_grant", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      check_eq("midrst_rsp_id", rsp_id, 1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      mptr = 1;
      rand_ops();
      run_txn(4'b1111, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
